aidc_mode_ctrl: RTL and testbench
=================================

# aidc_mode_ctrl

Multi-channel mode-switch controller for the next-generation AIDC datapath. It tracks outstanding write and read transactions per AXI channel pair. On a configuration change, it drains traffic and blocks new requests, then flips the effective compress/decompress enable only when the channel is quiescent, so no burst is ever split across modes. It sits between the APB configuration block and the per-channel address converters and data compress/decompress engines.

## Interface
Parameters:
- NUM_CH, 2, number of independent core/mem AXI channel pairs
- MAX_OUTSTANDING, 16, maximum outstanding transactions per direction per channel
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding-counter width

Ports:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_aidc_on_i  in  NUM_CH  requested mode per channel from CFG (1 = compress)
- aw_hs_i  in  NUM_CH  core AW handshake (awvalid & awready)
- b_hs_i  in  NUM_CH  core B handshake (bvalid & bready)
- ar_hs_i  in  NUM_CH  core AR handshake
- r_last_hs_i  in  NUM_CH  core R last-beat handshake (rvalid & rready & rlast)
- aw_block_o  out  NUM_CH  force core awready=0 and mem awvalid=0
- ar_block_o  out  NUM_CH  force core arready=0 and mem arvalid=0
- mode_o  out  NUM_CH  effective AIDC enable fed to the datapaths
- busy_o  out  NUM_CH  channel not in STABLE
- wr_cnt_o  out  NUM_CH*CNT_WIDTH  outstanding writes; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
- rd_cnt_o  out  NUM_CH*CNT_WIDTH  outstanding reads, packed the same way
- err_o  out  NUM_CH  sticky counter underflow/overflow

## Operation
- Reset values: mode_o=0 (bypass), all counts 0, state STABLE, aw_block_o=ar_block_o=0, busy_o=0, err_o=0.
- Counters, per channel and direction:
  - increment on aw_hs_i or ar_hs_i; decrement on b_hs_i or r_last_hs_i.
  - Simultaneous increment and decrement leaves the count unchanged.
  - Decrement at 0: count stays 0 and err_o is set.
  - Increment at MAX_OUTSTANDING: count saturates and err_o is set.
  - err_o is cleared only by reset.
- FSM per channel: STABLE, DRAIN, SWITCH.
  - STABLE: if cfg_aidc_on_i != mode_o, go to DRAIN.
  - DRAIN: if cfg_aidc_on_i == mode_o, go to STABLE (abort; mode unchanged). Otherwise, if wr_cnt==0 and rd_cnt==0 (registered values), go to SWITCH and load mode_o <= cfg_aidc_on_i.
  - SWITCH: unconditionally go to STABLE. This is a one-cycle guard so the datapath observes the new mode before traffic resumes.
- Abort takes priority over the zero-count check in the same cycle.
- aw_block_o = (state != STABLE) | (wr_cnt == MAX_OUTSTANDING). This is combinational from registered state, with no input-to-output path.
- ar_block_o = (state != STABLE) | (rd_cnt == MAX_OUTSTANDING).
- busy_o = (state != STABLE).
- Channels are fully independent. No shared state exists between channels.

## Timing
- Idle channel, cfg toggled before edge k:
  - DRAIN after edge k.
  - SWITCH after edge k+1, with mode_o updated at edge k+1.
  - STABLE after edge k+2.
  - Blocks are asserted for exactly 2 cycles.
- With outstanding traffic, mode_o updates at the first edge where DRAIN sees both counts 0. A decrement in cycle j makes the count 0 after edge j, so the switch occurs at edge j+1.
- Handshakes completing while a block is asserted are still counted. Handshake inputs are sampled every cycle in all states.
- An asynchronous reset during DRAIN or SWITCH returns the channel to reset values immediately. It does not wait for a clock edge.

## Structure
- Package `aidc_mode_pkg`:
  - enum `aidc_mode_state_t` with values STABLE, DRAIN, SWITCH.
  - localparam defaults for NUM_CH and MAX_OUTSTANDING.
- Sub-module `aidc_mode_ch`: one channel's two counters, FSM and error flag.
- `aidc_mode_ctrl` instantiates NUM_CH copies of `aidc_mode_ch` in a generate loop and packs their outputs.

## Test plan
- Reset then idle: after rst_n deasserts, all outputs are 0. Set cfg_aidc_on_i[0]=1 → mode_o[0]=1 two edges later; aw_block_o[0] and ar_block_o[0] are high for exactly 2 cycles; channel 1 is untouched.
- Drain: issue 3 AW handshakes, then toggle cfg → mode_o stays 0 and blocks stay high until the 3rd b_hs_i. mode_o flips one edge after wr_cnt reaches 0, and blocks drop one edge later.
- Abort: toggle cfg with rd_cnt=2, then restore cfg before the reads return → FSM returns to STABLE, mode_o never changes, and blocks drop the cycle after restore.
- Saturation: issue 16 AR handshakes with no R → ar_block_o is high at rd_cnt=16 and aw_block_o stays low. A 17th forced ar_hs_i sets err_o and rd_cnt stays 16.
- Simultaneous events and underflow: aw_hs_i and b_hs_i in the same cycle at wr_cnt=5 → wr_cnt stays 5. b_hs_i at wr_cnt=0 → wr_cnt stays 0 and err_o is set until reset.
- Mid-operation reset: assert rst_n=0 while in DRAIN with counts 4 and 2 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/aidc_mode_pkg.sv
// Shared types and defaults for the AIDC mode-switch controller.
package aidc_mode_pkg;

  localparam int unsigned NUM_CH_DEF          = 2;
  localparam int unsigned MAX_OUTSTANDING_DEF = 16;

  // Per-channel mode-switch state.
  typedef enum logic [1:0] {
    STABLE = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } aidc_mode_state_t;

  // Width needed to hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/aidc_mode_ctrl_if.sv
// Core-side AXI handshake observations and the request blocks returned to
// the address path, one bit per channel.
interface aidc_mode_ctrl_if #(
  parameter int unsigned NUM_CH = 2
);

  logic [NUM_CH-1:0] aw_hs_i;
  logic [NUM_CH-1:0] b_hs_i;
  logic [NUM_CH-1:0] ar_hs_i;
  logic [NUM_CH-1:0] r_last_hs_i;
  logic [NUM_CH-1:0] aw_block_o;
  logic [NUM_CH-1:0] ar_block_o;

  // Bus side: reports handshakes, honours the blocks.
  modport master (
    output aw_hs_i,
    output b_hs_i,
    output ar_hs_i,
    output r_last_hs_i,
    input  aw_block_o,
    input  ar_block_o
  );

  // Controller side: counts handshakes, drives the blocks.
  modport slave (
    input  aw_hs_i,
    input  b_hs_i,
    input  ar_hs_i,
    input  r_last_hs_i,
    output aw_block_o,
    output ar_block_o
  );

endinterface

// File: rtl/aidc_mode_ch.sv
// One channel: outstanding write/read counters, sticky error flag and the
// STABLE/DRAIN/SWITCH mode-change FSM.
module aidc_mode_ch
  import aidc_mode_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned CNT_WIDTH       = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_aidc_on_i,
  input  logic                 aw_hs_i,
  input  logic                 b_hs_i,
  input  logic                 ar_hs_i,
  input  logic                 r_last_hs_i,
  output logic                 aw_block_o,
  output logic                 ar_block_o,
  output logic                 mode_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  aidc_mode_state_t state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic             err_q, err_d;
  logic             wr_err, rd_err;

  // Write counter: saturating up/down, simultaneous inc+dec is a no-op.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_err   = 1'b0;
    if (aw_hs_i && !b_hs_i) begin
      if (wr_cnt_q == CNT_MAX) wr_err = 1'b1;
      else                     wr_cnt_d = wr_cnt_q + CNT_ONE;
    end else if (b_hs_i && !aw_hs_i) begin
      if (wr_cnt_q == '0) wr_err = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CNT_ONE;
    end
  end

  // Read counter: same rules as the write counter.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_err   = 1'b0;
    if (ar_hs_i && !r_last_hs_i) begin
      if (rd_cnt_q == CNT_MAX) rd_err = 1'b1;
      else                     rd_cnt_d = rd_cnt_q + CNT_ONE;
    end else if (r_last_hs_i && !ar_hs_i) begin
      if (rd_cnt_q == '0) rd_err = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CNT_ONE;
    end
  end

  // Sticky error: only reset clears it.
  always_comb begin
    err_d = err_q | wr_err | rd_err;
  end

  // Counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  // FSM state and effective-mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next state: abort beats the quiescence check; mode only loads on the
  // DRAIN->SWITCH transition, which uses the registered counts.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      STABLE: begin
        if (cfg_aidc_on_i != mode_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (cfg_aidc_on_i == mode_q) begin
          state_d = STABLE;
        end else if (wr_cnt_q == '0 && rd_cnt_q == '0) begin
          state_d = SWITCH;
          mode_d  = cfg_aidc_on_i;
        end
      end
      SWITCH: begin
        state_d = STABLE;
      end
      default: begin
        state_d = STABLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy_o     = (state_q != STABLE);
    aw_block_o = busy_o | (wr_cnt_q == CNT_MAX);
    ar_block_o = busy_o | (rd_cnt_q == CNT_MAX);
    mode_o     = mode_q;
    wr_cnt_o   = wr_cnt_q;
    rd_cnt_o   = rd_cnt_q;
    err_o      = err_q;
  end

endmodule

// File: rtl/aidc_mode_ctrl.sv
// Multi-channel AIDC mode-switch controller: drains each channel before
// flipping its compress enable so no burst straddles a mode change.
module aidc_mode_ctrl
  import aidc_mode_pkg::*;
#(
  parameter int unsigned NUM_CH          = NUM_CH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             cfg_aidc_on_i,
  aidc_mode_ctrl_if.slave               axi,
  output logic [NUM_CH-1:0]             mode_o,
  output logic [NUM_CH-1:0]             busy_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]   wr_cnt_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]   rd_cnt_o,
  output logic [NUM_CH-1:0]             err_o
);

  logic [NUM_CH-1:0] aw_block;
  logic [NUM_CH-1:0] ar_block;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aidc_mode_ch #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_aidc_on_i (cfg_aidc_on_i[i]),
      .aw_hs_i       (axi.aw_hs_i[i]),
      .b_hs_i        (axi.b_hs_i[i]),
      .ar_hs_i       (axi.ar_hs_i[i]),
      .r_last_hs_i   (axi.r_last_hs_i[i]),
      .aw_block_o    (aw_block[i]),
      .ar_block_o    (ar_block[i]),
      .mode_o        (mode_o[i]),
      .busy_o        (busy_o[i]),
      .wr_cnt_o      (wr_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .rd_cnt_o      (rd_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .err_o         (err_o[i])
    );
  end

  // Route per-channel blocks back onto the bus interface.
  always_comb begin
    axi.aw_block_o = aw_block;
    axi.ar_block_o = ar_block;
  end

endmodule

// File: tb/tb_aidc_mode_ctrl.sv
// Scoreboard bench for aidc_mode_ctrl: a cycle model predicts outputs for
// every driven cycle, the prediction is queued and compared after the edge.
module tb_aidc_mode_ctrl;

  localparam int unsigned NCH = 2;
  localparam int unsigned MAXO = 16;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] cfg;
  logic [NCH-1:0] mode_o, busy_o, err_o;
  logic [NCH*CW-1:0] wr_cnt_o, rd_cnt_o;

  aidc_mode_ctrl_if #(.NUM_CH(NCH)) axi_if ();

  aidc_mode_ctrl #(
    .NUM_CH          (NCH),
    .MAX_OUTSTANDING (MAXO),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_aidc_on_i (cfg),
    .axi           (axi_if),
    .mode_o        (mode_o),
    .busy_o        (busy_o),
    .wr_cnt_o      (wr_cnt_o),
    .rd_cnt_o      (rd_cnt_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              tag;
    logic [NCH-1:0]     mode, busy, awb, arb, err;
    logic [NCH*CW-1:0]  wr, rd;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model (0=STABLE, 1=DRAIN, 2=SWITCH).
  int m_state[NCH];
  int m_wr[NCH];
  int m_rd[NCH];
  bit m_mode[NCH];
  bit m_err[NCH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned c = 0; c < NCH; c++) begin
      m_state[c] = 0; m_wr[c] = 0; m_rd[c] = 0; m_mode[c] = 0; m_err[c] = 0;
    end
  endtask

  task automatic model_clock(input logic [NCH-1:0] c_cfg, aw, b, ar, r);
    for (int unsigned c = 0; c < NCH; c++) begin
      // FSM looks at counts from before this edge
      case (m_state[c])
        0: if (c_cfg[c] != m_mode[c]) m_state[c] = 1;
        1: begin
          if (c_cfg[c] == m_mode[c]) m_state[c] = 0;
          else if (m_wr[c] == 0 && m_rd[c] == 0) begin
            m_state[c] = 2;
            m_mode[c] = c_cfg[c];
          end
        end
        default: m_state[c] = 0;
      endcase
      if (aw[c] && !b[c]) begin
        if (m_wr[c] == MAXO) m_err[c] = 1; else m_wr[c]++;
      end else if (b[c] && !aw[c]) begin
        if (m_wr[c] == 0) m_err[c] = 1; else m_wr[c]--;
      end
      if (ar[c] && !r[c]) begin
        if (m_rd[c] == MAXO) m_err[c] = 1; else m_rd[c]++;
      end else if (r[c] && !ar[c]) begin
        if (m_rd[c] == 0) m_err[c] = 1; else m_rd[c]--;
      end
    end
  endtask

  function automatic exp_t model_out(input string tag);
    exp_t e;
    e.tag = tag;
    for (int unsigned c = 0; c < NCH; c++) begin
      e.mode[c] = m_mode[c];
      e.busy[c] = (m_state[c] != 0);
      e.awb[c]  = (m_state[c] != 0) || (m_wr[c] == MAXO);
      e.arb[c]  = (m_state[c] != 0) || (m_rd[c] == MAXO);
      e.err[c]  = m_err[c];
      e.wr[c*CW +: CW] = CW'(m_wr[c]);
      e.rd[c*CW +: CW] = CW'(m_rd[c]);
    end
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, ".mode"},   32'(mode_o),           32'(e.mode));
    check_eq({e.tag, ".busy"},   32'(busy_o),           32'(e.busy));
    check_eq({e.tag, ".awblk"},  32'(axi_if.aw_block_o), 32'(e.awb));
    check_eq({e.tag, ".arblk"},  32'(axi_if.ar_block_o), 32'(e.arb));
    check_eq({e.tag, ".err"},    32'(err_o),            32'(e.err));
    check_eq({e.tag, ".wr_cnt"}, 32'(wr_cnt_o),         32'(e.wr));
    check_eq({e.tag, ".rd_cnt"}, 32'(rd_cnt_o),         32'(e.rd));
  endtask

  // One clock cycle of stimulus; the prediction is queued, then checked after the edge.
  task automatic step(input logic [NCH-1:0] c_cfg, aw, b, ar, r, input string tag);
    @(negedge clk);
    cfg = c_cfg;
    axi_if.aw_hs_i = aw;
    axi_if.b_hs_i = b;
    axi_if.ar_hs_i = ar;
    axi_if.r_last_hs_i = r;
    model_clock(c_cfg, aw, b, ar, r);
    sb.push_back(model_out(tag));
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned k = 0; k < n; k++) step(cfg, '0, '0, '0, '0, tag);
  endtask

  // Asynchronous reset applied away from any clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cfg = '0;
    axi_if.aw_hs_i = '0;
    axi_if.b_hs_i = '0;
    axi_if.ar_hs_i = '0;
    axi_if.r_last_hs_i = '0;
    model_reset();
    sb.push_back(model_out(tag));
    #1;
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] rc, ra, rb, rr, rcf;
    cfg = '0;
    axi_if.aw_hs_i = '0;
    axi_if.b_hs_i = '0;
    axi_if.ar_hs_i = '0;
    axi_if.r_last_hs_i = '0;
    model_reset();

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_out("reset"));
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, "idle");

    // Idle mode switch on channel 0
    step(2'b01, '0, '0, '0, '0, "sw_drain");
    step(2'b01, '0, '0, '0, '0, "sw_switch");
    step(2'b01, '0, '0, '0, '0, "sw_stable");
    check_eq("sw_mode0", 32'(mode_o), 32'h1);
    idle(1, "sw_idle");

    // Drain with three outstanding writes, switching back to bypass
    for (int unsigned k = 0; k < 3; k++) step(2'b01, 2'b01, '0, '0, '0, "dr_aw");
    step(2'b00, '0, '0, '0, '0, "dr_enter");
    idle(2, "dr_wait");
    step(2'b00, '0, 2'b01, '0, '0, "dr_b1");
    step(2'b00, '0, 2'b01, '0, '0, "dr_b2");
    step(2'b00, '0, 2'b01, '0, '0, "dr_b3");
    check_eq("dr_mode_held", 32'(mode_o), 32'h1);
    step(2'b00, '0, '0, '0, '0, "dr_switch");
    check_eq("dr_mode_flip", 32'(mode_o), 32'h0);
    step(2'b00, '0, '0, '0, '0, "dr_stable");
    check_eq("dr_block_drop", 32'(axi_if.aw_block_o), 32'h0);

    // Abort with two outstanding reads
    step(2'b00, '0, '0, 2'b01, '0, "ab_ar1");
    step(2'b00, '0, '0, 2'b01, '0, "ab_ar2");
    step(2'b01, '0, '0, '0, '0, "ab_drain");
    step(2'b01, '0, '0, '0, '0, "ab_hold");
    step(2'b00, '0, '0, '0, '0, "ab_restore");
    check_eq("ab_busy", 32'(busy_o), 32'h0);
    step(2'b00, '0, '0, '0, 2'b01, "ab_r1");
    step(2'b00, '0, '0, '0, 2'b01, "ab_r2");
    check_eq("ab_mode", 32'(mode_o), 32'h0);

    // Read saturation on channel 1
    for (int unsigned k = 0; k < MAXO; k++) step(2'b00, '0, '0, 2'b10, '0, "sat_ar");
    check_eq("sat_arblk1", 32'(axi_if.ar_block_o[1]), 32'h1);
    check_eq("sat_awblk1", 32'(axi_if.aw_block_o[1]), 32'h0);
    step(2'b00, '0, '0, 2'b10, '0, "sat_over");
    check_eq("sat_err1", 32'(err_o[1]), 32'h1);
    check_eq("sat_rd1", 32'(rd_cnt_o[CW +: CW]), 32'd16);

    // Simultaneous inc/dec at 5, then underflow on channel 0
    for (int unsigned k = 0; k < 5; k++) step(2'b00, 2'b01, '0, '0, '0, "sim_aw");
    step(2'b00, 2'b01, 2'b01, '0, '0, "sim_both");
    check_eq("sim_wr5", 32'(wr_cnt_o[0 +: CW]), 32'd5);
    for (int unsigned k = 0; k < 5; k++) step(2'b00, '0, 2'b01, '0, '0, "sim_b");
    step(2'b00, '0, 2'b01, '0, '0, "udf_b");
    check_eq("udf_err0", 32'(err_o[0]), 32'h1);
    idle(2, "udf_sticky");

    // Asynchronous reset while draining with counts 4/2
    async_reset("rst_clean");
    for (int unsigned k = 0; k < 4; k++) step(2'b00, 2'b01, '0, '0, '0, "mr_aw");
    for (int unsigned k = 0; k < 2; k++) step(2'b00, '0, '0, 2'b01, '0, "mr_ar");
    step(2'b01, '0, '0, '0, '0, "mr_drain");
    check_eq("mr_busy", 32'(busy_o), 32'h1);
    async_reset("mr_async");

    // Short random mix on both channels
    for (int unsigned k = 0; k < 80; k++) begin
      rcf = NCH'($urandom_range(0, 3));
      ra  = NCH'($urandom_range(0, 3));
      rb  = NCH'($urandom_range(0, 3));
      rc  = NCH'($urandom_range(0, 3));
      rr  = NCH'($urandom_range(0, 3));
      step((k % 8 < 4) ? cfg : rcf, ra, rb, rc, rr, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
